// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch front end:
//   - fetch FSM state encoding (IDLE / REQ / DRAIN)
//   - queue depth and the default NOP instruction word
//   - the {pc, inst} entry type carried through the fetch queue
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int          FETCH_DEPTH      = 2;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    // IDLE : nothing outstanding on the memory port
    // REQ  : request outstanding, its response will be queued
    // DRAIN: request outstanding, its response will be thrown away (post-flush)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
// Two-entry FIFO of {pc, inst} pairs between the fetch logic and IF/ID.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   clear       : drop every entry (redirect); wins over push/pop
//   push        : write push_entry at the tail
//   pop         : retire the head entry
//   push_entry  : entry written on push
//   head        : current head entry (contents undefined when count == 0)
//   count       : number of valid entries, 0..2
// -----------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slots [FETCH_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    // With two slots the tail is the head slot when the queue holds an even
    // number of entries and the other slot when it holds one. In the full +
    // pop + push case this writes the slot being vacated by the pop.
    assign wr_ptr = rd_ptr ^ count[0];
    assign head   = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (clear) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_entry;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end. Turns the PC register value into instruction
// memory reads, advances the PC only when a fetch lands in the queue, and
// feeds the IF/ID stage from a 2-entry {pc, inst} queue. A flush empties the
// queue and discards any response still in flight.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   iPC                    : current PC from the PC register
//   PCWrite                : PC register advance enable (high on each push)
//   imem_req/imem_addr     : instruction memory request and address
//   imem_ack/imem_rdata    : memory response strobe and data
//   flush                  : redirect pulse from branch/jump resolution
//   stall_in               : ID stage cannot accept this cycle
//   oValid/oInst/oPC       : queue head towards IF/ID
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iPC,
    output logic        PCWrite,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic        stall_in,
    output logic        oValid,
    output logic [31:0] oInst,
    output logic [31:0] oPC
);

    localparam logic [1:0] FULL_COUNT = DEPTH[1:0];

    logic [1:0]   state;
    logic [1:0]   state_n;
    logic [31:0]  held_addr;
    logic [1:0]   count;
    logic [1:0]   count_n;
    logic         push;
    logic         pop;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    // Queue events for this cycle. Flush beats both push and pop, and the
    // count we will hold after the edge decides whether a new request may go.
    always_comb begin
        push    = (state == ST_REQ) & imem_ack & ~flush;
        pop     = (count != 2'd0) & ~stall_in & ~flush;
        count_n = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
    end

    // Fetch FSM. A flush with a request still outstanding cannot cancel the
    // memory transaction, so we move to DRAIN and wait for (and drop) its ack.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (!flush && (count_n < FULL_COUNT)) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (flush) begin
                        state_n = ST_REQ;
                    end else if (count_n < FULL_COUNT) begin
                        state_n = ST_REQ;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (flush) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // held_addr shadows iPC so that the address of a request being drained
    // stays stable after the PC register has already taken the redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            held_addr <= 32'd0;
        end else begin
            state <= state_n;
            if (state != ST_DRAIN) begin
                held_addr <= iPC;
            end
        end
    end

    assign imem_req   = (state != ST_IDLE);
    assign imem_addr  = (state == ST_DRAIN) ? held_addr : iPC;
    assign PCWrite    = push;
    assign push_entry = '{pc: imem_addr, inst: imem_rdata};

    if_fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign oValid = (count != 2'd0);
    assign oInst  = oValid ? head.inst : NOP_INST;
    assign oPC    = oValid ? head.pc   : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit. The bench also plays the PC
// register (reset to 0x00400000, +4 on each fetch, jump on flush) and the
// instruction memory. A reference model of the fetch unit (a queue of
// {pc, inst} entries plus "request outstanding" / "discard response" flags)
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iPC;
    logic        PCWrite;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        stall_in;
    logic        oValid;
    logic [31:0] oInst;
    logic [31:0] oPC;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .iPC        (iPC),
        .PCWrite    (PCWrite),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .stall_in   (stall_in),
        .oValid     (oValid),
        .oInst      (oInst),
        .oPC        (oPC)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ref_entry_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        ack;
        logic        flsh;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_pcw;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    // Reference model state
    ref_entry_t  ref_q[$];
    logic        ref_busy;
    logic        ref_discard;
    logic [31:0] ref_held;
    logic [31:0] ref_pc;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] instFor(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic expectVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        ref_q.delete();
        ref_busy    = 1'b0;
        ref_discard = 1'b0;
        ref_held    = 32'd0;
        ref_pc      = RESET_PC;
    endtask

    // Drive one cycle of inputs half a period before the active edge.
    task automatic applyStimulus(input logic r, input logic st, input logic ak,
                                 input logic fl, input logic [31:0] tgt,
                                 input logic [31:0] rd);
        @(negedge clk);
        iPC         = ref_pc;
        reset       = r;
        stall_in    = st;
        imem_ack    = ak;
        flush       = fl;
        imem_rdata  = rd;
        redirect_pc = tgt;
        #1;
    endtask

    // Compare DUT against the model for this cycle, then advance the model
    // (and the PC register) as the coming clock edge will.
    task automatic checkOutput();
        logic [31:0] e_addr;
        logic        e_push;
        logic        e_pop;
        logic        e_valid;
        int          n;
        e_addr  = ref_discard ? ref_held : iPC;
        e_push  = ref_busy && !ref_discard && imem_ack && !flush;
        e_valid = (ref_q.size() != 0);
        e_pop   = e_valid && !stall_in && !flush;
        expectVal("imem_req", {31'd0, imem_req}, {31'd0, ref_busy});
        expectVal("imem_addr", imem_addr, e_addr);
        expectVal("PCWrite", {31'd0, PCWrite}, {31'd0, e_push});
        expectVal("oValid", {31'd0, oValid}, {31'd0, e_valid});
        expectVal("oPC", oPC, e_valid ? ref_q[0].pc : 32'd0);
        expectVal("oInst", oInst, e_valid ? ref_q[0].inst : 32'd0);

        if (reset) begin
            modelReset();
        end else begin
            if (!ref_discard) ref_held = iPC;
            if (flush) ref_q.delete();
            else begin
                if (e_pop) void'(ref_q.pop_front());
                if (e_push) ref_q.push_back('{pc: e_addr, inst: imem_rdata});
            end
            n = ref_q.size();
            if (flush) ref_pc = redirect_pc;
            else if (e_push) ref_pc = ref_pc + 32'd4;
            if (!ref_busy) begin
                ref_busy = !flush && (n < 2);
            end else if (ref_discard) begin
                if (imem_ack) ref_discard = 1'b0;
            end else if (imem_ack) begin
                ref_busy = flush || (n < 2);
            end else if (flush) begin
                ref_discard = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic st, input logic ak,
                        input logic fl, input logic [31:0] tgt);
        applyStimulus(r, st, ak, fl, tgt, instFor(ref_pc));
        checkOutput();
    endtask

    vec_t vecs[9];
    int   pushes;

    initial begin
        // Reset then zero-wait fetch from 0x00400000
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0004, 1'b1, 1'b1, 32'h0040_0000};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0008, 1'b1, 1'b1, 32'h0040_0004};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_000C, 1'b0, 1'b1, 32'h0040_0008};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_000C, 1'b0, 1'b0, 32'h0};

        modelReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].ack, vecs[i].flsh,
                          32'd0, instFor(ref_pc));
            expectVal($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            expectVal($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            expectVal($sformatf("vec%0d_pcwrite", i), {31'd0, PCWrite}, {31'd0, vecs[i].exp_pcw});
            expectVal($sformatf("vec%0d_valid", i), {31'd0, oValid}, {31'd0, vecs[i].exp_valid});
            expectVal($sformatf("vec%0d_opc", i), oPC, vecs[i].exp_pc);
            expectVal($sformatf("vec%0d_oinst", i), oInst,
                      vecs[i].exp_valid ? instFor(vecs[i].exp_pc) : 32'd0);
            checkOutput();
        end

        // Stall held 10 cycles: queue fills after exactly two pushes
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, ref_busy, 1'b0, 32'd0, instFor(ref_pc));
            if (PCWrite === 1'b1) pushes++;
            checkOutput();
        end
        expectVal("stall_pushes", pushes, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, instFor(ref_pc));
        expectVal("full_req", {31'd0, imem_req}, 32'd0);
        expectVal("full_pcwrite", {31'd0, PCWrite}, 32'd0);
        expectVal("full_head", oPC, 32'h0040_000C);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, instFor(ref_pc));
        expectVal("resume_head", oPC, 32'h0040_0010);
        expectVal("resume_addr", imem_addr, 32'h0040_0014);
        expectVal("resume_req", {31'd0, imem_req}, 32'd1);
        checkOutput();

        // Flush during a delayed ack: the in-flight response is drained
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 32'd0);
        expectVal("flushwait_addr", imem_addr, 32'h0040_0008);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        expectVal("drain_addr", imem_addr, 32'h0040_0008);
        expectVal("drain_req", {31'd0, imem_req}, 32'd1);
        checkOutput();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'hBAD0_BAD0);
        expectVal("drain_ack_pcwrite", {31'd0, PCWrite}, 32'd0);
        expectVal("drain_ack_addr", imem_addr, 32'h0040_0008);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        expectVal("redirect_addr", imem_addr, 32'h0040_0100);
        expectVal("redirect_valid", {31'd0, oValid}, 32'd0);
        checkOutput();

        // Flush coincident with ack while an entry is queued
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0200, instFor(ref_pc));
        expectVal("flushack_pcwrite", {31'd0, PCWrite}, 32'd0);
        expectVal("flushack_head", oPC, 32'h0040_0100);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        expectVal("postflush_valid", {31'd0, oValid}, 32'd0);
        expectVal("postflush_addr", imem_addr, 32'h0040_0200);
        checkOutput();

        // Reset while a request is outstanding with one queued entry
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        expectVal("prereset_valid", {31'd0, oValid}, 32'd1);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1234_5678);
        expectVal("postreset_valid", {31'd0, oValid}, 32'd0);
        expectVal("postreset_req", {31'd0, imem_req}, 32'd0);
        expectVal("postreset_pcwrite", {31'd0, PCWrite}, 32'd0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        expectVal("lateack_valid", {31'd0, oValid}, 32'd0);
        expectVal("lateack_addr", imem_addr, RESET_PC);
        checkOutput();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic        r;
            logic        st;
            logic        ak;
            logic        fl;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 99) < 30);
            ak  = ref_busy && ($urandom_range(0, 99) < 60);
            fl  = ($urandom_range(0, 99) < 5);
            tgt = RESET_PC | ($urandom & 32'h0000_FFFC);
            applyStimulus(r, st, ak, fl, tgt, $urandom);
            checkOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end that reads the program counter register and turns it into instruction memory reads. It drives PCWrite back to the PC register so the PC advances only when a fetch completes. Fetched {pc, instruction} pairs go into a 2-entry queue that feeds the IF/ID stage. Branch/jump redirects are handled by a flush that discards queued entries and any in-flight response.

Parameters:
DEPTH, 2, fetch queue entries. Fixed at 2; the count logic assumes it.
NOP_INST, 32'h00000000, value driven on oInst when the queue is empty.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
iPC  input  32  current PC from the PC register
PCWrite  output  1  advance enable to the PC register
imem_req  output  1  instruction memory request
imem_addr  output  32  request address
imem_ack  input  1  memory response valid; imem_rdata is valid in this cycle
imem_rdata  input  32  fetched instruction
flush  input  1  redirect pulse from branch/jump resolution
stall_in  input  1  ID stage cannot accept this cycle
oValid  output  1  queue head valid
oInst  output  32  queue head instruction
oPC  output  32  queue head PC

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: state IDLE, count 0, oValid 0, oInst NOP_INST, oPC 0, imem_req 0, PCWrite 0, held_addr 0.
- States:
  - IDLE: no outstanding request.
  - REQ: request outstanding, response will be kept.
  - DRAIN: request outstanding, response will be discarded.
- imem_req = (state != IDLE).
- imem_addr = held_addr in DRAIN, otherwise iPC. held_addr <= iPC every cycle in IDLE or REQ.
- Memory protocol: once imem_req is high, it and imem_addr stay stable until the ack cycle. At most one request is outstanding.
- Per-cycle events:
  - push = (state == REQ) & imem_ack & ~flush
  - pop = oValid & ~stall_in & ~flush
  - count_n = flush ? 0 : count + push - pop
- PCWrite = push, combinational. The PC register captures the next PC on the same edge the entry is pushed.
- Pushed entry = {imem_addr, imem_rdata}. The queue is FIFO-ordered; the head drives oPC/oInst. When empty, oInst = NOP_INST and oPC = 0.
- oValid = (count != 0).
- Transitions:
  - IDLE -> REQ when ~flush & count_n < 2.
  - REQ, imem_ack & ~flush -> REQ if count_n < 2, else IDLE. Back-to-back fetch, 1 instruction/cycle with a zero-wait memory.
  - REQ, imem_ack & flush -> REQ. Data dropped; the new iPC is fetched.
  - REQ, ~imem_ack & flush -> DRAIN.
  - DRAIN, imem_ack -> REQ. Data dropped, no PCWrite. A further flush while in DRAIN keeps DRAIN until ack.
- Latency: ack at cycle N -> oValid=1 at N+1 if the queue was empty.
- Full queue (count=2): no request issued. A pop and a push in the same cycle are both permitted.
- Flush has priority over push and pop. The queue is empty the cycle after a flush.
- Reset asserted mid-request: all state returns to reset values at the next edge. A late ack arriving after reset is ignored because state is IDLE.

Decomposition:
- Shared package: state encoding (IDLE/REQ/DRAIN) and the NOP_INST constant.
- One sub-module: if_fetch_queue, the 2-entry {pc, inst} FIFO with push/pop/clear and count.

Test Plan:
1. reset=1 for 3 cycles, iPC=0x00400000 -> imem_req=0, oValid=0, PCWrite=0 throughout. After release, imem_req=1 with imem_addr=0x00400000 on the next cycle.
2. Zero-wait memory (ack whenever req), stall_in=0 -> PCWrite high every ack cycle; oPC sequence 0x00400000, 0x00400004, 0x00400008 on consecutive cycles with oValid=1.
3. stall_in=1 held 10 cycles -> exactly 2 pushes, then imem_req=0 and PCWrite=0. On release, heads pop in order and fetch resumes with the next iPC.
4. Ack delayed 3 cycles, flush on cycle 1 of the wait with iPC redirected to 0x00400100 -> DRAIN; imem_addr stays 0x00400008; data dropped with no PCWrite; next request addr is 0x00400100.
5. flush coincident with imem_ack and a queued entry -> PCWrite=0, no push, oValid=0 next cycle.
6. reset asserted while in REQ with 1 queued entry -> next cycle count=0, oValid=0, imem_req=0; an ack in that cycle causes no push.
